// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic md_op_valid(input logic [2:0] op);
    return (op != MD_NONE) && (op <= MD_MTLO);
  endfunction

  function automatic logic md_op_long(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational product / quotient-remainder datapath for md_unit.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        is_signed;
  logic [63:0] ext_a, ext_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);

    ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = ext_a * ext_b;

    // Signed division through magnitudes: 0x80000000 / -1 wraps back to 0x80000000.
    a_neg    = is_signed && a[31];
    b_neg    = is_signed && b[31];
    a_mag    = a_neg ? (32'd0 - a) : a;
    b_mag    = b_neg ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      MD_MULT, MD_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_hi = rem;
        res_lo = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide sequencer: fixed-latency busy window, HI/LO commit, D-stage stall.
// state  | meaning
// S_IDLE | ready to accept; mthi/mtlo complete here in one edge
// S_MULT | mult/multu result held in shadow regs, counting down
// S_DIV  | div/divu result held in shadow regs, counting down
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_s_q, hi_s_d, lo_s_q, lo_s_d;

  logic [31:0] res_hi, res_lo;
  logic        div_zero;
  logic        accept;
  md_op_e      op;

  md_calc u_calc (
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign op     = md_op_e'(md_op);
  assign accept = start && !flush && (state_q == S_IDLE) && md_op_valid(md_op);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_s_d  = hi_s_q;
    lo_s_d  = lo_s_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              hi_s_d  = res_hi;
              lo_s_d  = res_lo;
              state_d = S_MULT;
              cnt_d   = MULT_CNT;
            end
            MD_DIV, MD_DIVU: begin
              // Divide by zero commits the current HI/LO back onto themselves.
              hi_s_d  = div_zero ? hi_q : res_hi;
              lo_s_d  = div_zero ? lo_q : res_lo;
              state_d = S_DIV;
              cnt_d   = DIV_CNT;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MULT, S_DIV: begin
        if (cnt_q == CNT_ONE) begin
          hi_d    = hi_s_q;
          lo_d    = lo_s_q;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_s_q  <= '0;
      lo_s_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_s_q  <= hi_s_d;
      lo_s_q  <= lo_s_d;
    end
  end

  // A start that cannot be taken (busy or undefined opcode) points to a hazard-unit bug.
  always_ff @(posedge clk) begin
    if (reset_n && start && !flush && !((state_q == S_IDLE) && md_op_valid(md_op)))
      $warning("md_unit: start ignored (md_op=%0d busy=%0b)", md_op, busy);
  end

  assign busy     = (state_q != S_IDLE);
  assign md_stall = busy | (start & md_op_long(md_op) & ~flush);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed plus randomized bench for md_unit against an arithmetic HI/LO model.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic        flush;
  logic [31:0] a, b;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = 32'd0;
  logic [31:0] exp_lo   = 32'd0;
  logic        exp_busy = 1'b0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .md_op    (md_op),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Returns the busy latency the op should produce; updates exp_hi/exp_lo to the committed result.
  function automatic int model_exec(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    int                ia, ib;
    longint            sa, sb, r, q, m;
    longint unsigned   ua, ub, ur;
    ia = av; ib = bv;
    sa = ia; sb = ib;
    ua = {32'd0, av}; ub = {32'd0, bv};
    case (op)
      3'd1: begin r = sa * sb; exp_hi = r[63:32]; exp_lo = r[31:0]; return MULT_N; end
      3'd2: begin ur = ua * ub; exp_hi = ur[63:32]; exp_lo = ur[31:0]; return MULT_N; end
      3'd3: begin
        if (bv != 0) begin q = sa / sb; m = sa % sb; exp_lo = q[31:0]; exp_hi = m[31:0]; end
        return DIV_N;
      end
      3'd4: begin
        if (bv != 0) begin ur = ua / ub; exp_lo = ur[31:0]; ur = ua % ub; exp_hi = ur[31:0]; end
        return DIV_N;
      end
      3'd5: begin exp_hi = av; return 0; end
      3'd6: begin exp_lo = av; return 0; end
      default: return 0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv, input logic fl);
    logic exp_stall;
    start = 1'b1; md_op = op; a = av; b = bv; flush = fl;
    exp_stall = exp_busy | ((op >= 3'd1) && (op <= 3'd4) && !fl);
    #1;
    chk("md_stall", {63'd0, md_stall}, {63'd0, exp_stall});
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0; flush = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string tag, input int n_exp);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk(tag, 64'(cnt), 64'(n_exp));
  endtask

  task automatic check_hilo(input string tag);
    chk({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int          lat;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset_n = 1'b0; start = 1'b0; md_op = 3'd0; flush = 1'b0; a = '0; b = '0;
    #3;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.stall", {63'd0, md_stall}, 64'd0);
    check_hilo("reset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: signed and unsigned multiply of 0xFFFFFFFF * 2
    drive(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check_hilo("mult.hold");
    lat = model_exec(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult.busy", lat);
    chk("mult.hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("mult.lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);
    drive(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    lat = model_exec(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu.busy", lat);
    chk("multu.hi", {32'd0, hi}, 64'h1);
    chk("multu.lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);

    // 2: signed -7/2 and unsigned 7/2
    drive(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    lat = model_exec(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div.busy", lat);
    chk("div.lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    chk("div.hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    drive(3'd4, 32'd7, 32'd2, 1'b0);
    lat = model_exec(3'd4, 32'd7, 32'd2);
    wait_done("divu.busy", lat);
    chk("divu.lo", {32'd0, lo}, 64'd3);
    chk("divu.hi", {32'd0, hi}, 64'd1);

    // signed overflow case
    drive(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    lat = model_exec(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divovf.busy", lat);
    chk("divovf.lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
    chk("divovf.hi", {32'd0, hi}, 64'd0);

    // 3: back-to-back mthi/mtlo
    drive(3'd5, 32'h1234, 32'd0, 1'b0);
    lat = model_exec(3'd5, 32'h1234, 32'd0);
    chk("mthi.busy", {63'd0, busy}, 64'd0);
    chk("mthi.hi", {32'd0, hi}, 64'h1234);
    drive(3'd6, 32'h5678, 32'd0, 1'b0);
    lat = model_exec(3'd6, 32'h5678, 32'd0);
    chk("mtlo.busy", {63'd0, busy}, 64'd0);
    chk("mtlo.lo", {32'd0, lo}, 64'h5678);

    // 4: divide by zero leaves HI/LO alone but keeps the latency
    drive(3'd5, 32'hAA, 32'd0, 1'b0);
    drive(3'd6, 32'hBB, 32'd0, 1'b0);
    lat = model_exec(3'd5, 32'hAA, 32'd0);
    lat = model_exec(3'd6, 32'hBB, 32'd0);
    drive(3'd3, 32'd1234, 32'd0, 1'b0);
    lat = model_exec(3'd3, 32'd1234, 32'd0);
    wait_done("divz.busy", lat);
    chk("divz.hi", {32'd0, hi}, 64'hAA);
    chk("divz.lo", {32'd0, lo}, 64'hBB);

    // 5a: flushed mult is dropped
    drive(3'd1, 32'd9, 32'd9, 1'b1);
    chk("flush.busy", {63'd0, busy}, 64'd0);
    check_hilo("flush");

    // 5b: mult issued during an in-flight div is ignored
    drive(3'd4, 32'd100, 32'd7, 1'b0);
    lat = model_exec(3'd4, 32'd100, 32'd7);
    @(posedge clk); #1;
    exp_busy = 1'b1;
    drive(3'd1, 32'd3, 32'd3, 1'b0);
    exp_busy = 1'b0;
    wait_done("divbusy.busy", lat - 2);
    check_hilo("divbusy");
    chk("divbusy.idle", {63'd0, busy}, 64'd0);

    // 6: asynchronous reset in the middle of a mult
    drive(3'd1, 32'd11, 32'd13, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    chk("rst.busy", {63'd0, busy}, 64'd0);
    check_hilo("rst");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    drive(3'd2, 32'd3, 32'd4, 1'b0);
    lat = model_exec(3'd2, 32'd3, 32'd4);
    wait_done("rst.multu.busy", lat);
    chk("rst.multu.lo", {32'd0, lo}, 64'd12);
    chk("rst.multu.hi", {32'd0, hi}, 64'd0);

    // randomized sequence, each op issued in the first idle cycle
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 50));
        default: ;
      endcase
      drive(rop, ra, rb, 1'b0);
      lat = model_exec(rop, ra, rb);
      if (lat == 0) chk("rnd.busy0", {63'd0, busy}, 64'd0);
      else          wait_done("rnd.busy", lat);
      check_hilo("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
